// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bundle layout, ALU encodings,
// and opcode/funct constants used by the decode and execute stages.
package mips_pkg;

    localparam int CTL_W = 12;

    // Control bundle bit positions: {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemtoReg,Jump,Bne,ALUControl[3:0]}
    localparam int CTL_REGWRITE = 11;
    localparam int CTL_REGDST   = 10;
    localparam int CTL_ALUSRC   = 9;
    localparam int CTL_BRANCH   = 8;
    localparam int CTL_MEMWRITE = 7;
    localparam int CTL_MEMTOREG = 6;
    localparam int CTL_JUMP     = 5;
    localparam int CTL_BNE      = 4;
    localparam int CTL_ALU_MSB  = 3;
    localparam int CTL_ALU_LSB  = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_NOR  = 4'b0101,
        ALU_SLT  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLLV = 4'b1011,
        ALU_SRLV = 4'b1100,
        ALU_SRAV = 4'b1101,
        ALU_LUI  = 4'b1110
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// (rt) feeds either source of the instruction currently in ID.
module load_use_detect (
    input  logic       valid_e,
    input  logic       mem_to_reg_e,
    input  logic       valid_d,
    input  logic [4:0] rt_e,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    output logic       lu
);

    always_comb begin
        lu = valid_e & mem_to_reg_e & valid_d & (rt_e != '0)
           & ((rt_e == rs_d) | (rt_e == rt_d));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/stall
// priority handling and a saturating bubble counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CTL_W-1:0] ctl_d,
    input  logic             valid_d,
    input  logic [DW-1:0]    rd1_d,
    input  logic [DW-1:0]    rd2_d,
    input  logic [DW-1:0]    simm_d,
    input  logic [DW-1:0]    pcp4_d,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rd_d,
    input  logic [4:0]       shamt_d,
    input  logic             stall_e,
    input  logic             flush_e,
    output logic [CTL_W-1:0] ctl_e,
    output logic             valid_e,
    output logic [DW-1:0]    rd1_e,
    output logic [DW-1:0]    rd2_e,
    output logic [DW-1:0]    simm_e,
    output logic [DW-1:0]    pcp4_e,
    output logic [4:0]       rs_e,
    output logic [4:0]       rt_e,
    output logic [4:0]       rd_e,
    output logic [4:0]       shamt_e,
    output logic             stall_fd,
    output logic [CW-1:0]    bubble_cnt
);

    logic lu;

    load_use_detect u_load_use_detect (
        .valid_e      (valid_e),
        .mem_to_reg_e (ctl_e[CTL_MEMTOREG]),
        .valid_d      (valid_d),
        .rt_e         (rt_e),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .lu           (lu)
    );

    always_comb begin
        stall_fd = stall_e | (lu & ~flush_e);
    end

    // Datapath fields load even on a bubble; only valid_e/ctl_e carry kill semantics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_e      <= '0;
            valid_e    <= 1'b0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            simm_e     <= '0;
            pcp4_e     <= '0;
            rs_e       <= '0;
            rt_e       <= '0;
            rd_e       <= '0;
            shamt_e    <= '0;
            bubble_cnt <= '0;
        end else if (!stall_e) begin
            rd1_e   <= rd1_d;
            rd2_e   <= rd2_d;
            simm_e  <= simm_d;
            pcp4_e  <= pcp4_d;
            rs_e    <= rs_d;
            rt_e    <= rt_d;
            rd_e    <= rd_d;
            shamt_e <= shamt_d;
            if (flush_e || lu) begin
                valid_e <= 1'b0;
                ctl_e   <= '0;
            end else begin
                valid_e <= valid_d;
                ctl_e   <= valid_d ? ctl_d : '0;
            end
            if (lu && !flush_e && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations into a
// queue, a monitor pops them and checks stall_fd before and EX outputs after the edge.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    localparam logic [11:0] C_LW  = 12'hA40;
    localparam logic [11:0] C_ADD = 12'hC00;
    localparam logic [11:0] C_SUB = 12'hC01;

    logic clk = 1'b0;
    logic reset;
    logic [11:0] ctl_d;
    logic valid_d;
    logic [DW-1:0] rd1_d, rd2_d, simm_d, pcp4_d;
    logic [4:0] rs_d, rt_d, rd_d, shamt_d;
    logic stall_e, flush_e;
    logic [11:0] ctl_e;
    logic valid_e;
    logic [DW-1:0] rd1_e, rd2_e, simm_e, pcp4_e;
    logic [4:0] rs_e, rt_e, rd_e, shamt_e;
    logic stall_fd;
    logic [CW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .ctl_d(ctl_d), .valid_d(valid_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .simm_d(simm_d), .pcp4_d(pcp4_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .shamt_d(shamt_d),
        .stall_e(stall_e), .flush_e(flush_e),
        .ctl_e(ctl_e), .valid_e(valid_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .simm_e(simm_e), .pcp4_e(pcp4_e),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .shamt_e(shamt_e),
        .stall_fd(stall_fd), .bubble_cnt(bubble_cnt)
    );

    typedef enum {LOAD, HOLD, BUB} kind_t;

    typedef struct {
        string       tag;
        logic        sfd;
        logic        v;
        logic [11:0] ctl;
        logic [CW-1:0] cnt;
        bit          chk_data;
        logic [31:0] rd1, rd2, simm, pcp4;
        logic [19:0] regs;
    } exp_t;

    exp_t q[$];
    exp_t last;
    bit   last_ok = 0;
    int   seq = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [11:0] c,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic st, input logic fl,
                        input logic e_sfd, input logic e_v, input logic [11:0] e_ctl,
                        input logic [CW-1:0] e_cnt, input kind_t k);
        exp_t e;
        @(negedge clk);
        seq++;
        valid_d = v;
        ctl_d   = c;
        rs_d    = rs;
        rt_d    = rt;
        rd_d    = 5'(seq + 3);
        shamt_d = 5'(seq);
        rd1_d   = 32'h1000_0000 + 32'(seq);
        rd2_d   = 32'h2000_0000 - 32'(seq);
        simm_d  = (seq % 2 == 1) ? -32'(seq) : 32'(seq);
        pcp4_d  = 32'h0040_0000 + 32'(4 * seq);
        stall_e = st;
        flush_e = fl;
        e.tag = tag;
        e.sfd = e_sfd;
        e.v   = e_v;
        e.ctl = e_ctl;
        e.cnt = e_cnt;
        case (k)
            LOAD: begin
                e.chk_data = 1;
                e.rd1 = rd1_d; e.rd2 = rd2_d; e.simm = simm_d; e.pcp4 = pcp4_d;
                e.regs = {rs_d, rt_d, rd_d, shamt_d};
                last = e;
                last_ok = 1;
            end
            HOLD: begin
                e.chk_data = last_ok;
                e.rd1 = last.rd1; e.rd2 = last.rd2; e.simm = last.simm; e.pcp4 = last.pcp4;
                e.regs = last.regs;
            end
            default: begin
                e.chk_data = 0;
                e.rd1 = '0; e.rd2 = '0; e.simm = '0; e.pcp4 = '0; e.regs = '0;
                last_ok = 0;
            end
        endcase
        q.push_back(e);
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".stall_fd"}, 32'(stall_fd), 32'(e.sfd));
                @(posedge clk);
                #1;
                chk({e.tag, ".valid_e"}, 32'(valid_e), 32'(e.v));
                chk({e.tag, ".ctl_e"}, 32'(ctl_e), 32'(e.ctl));
                chk({e.tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(e.cnt));
                if (e.chk_data) begin
                    chk({e.tag, ".rd1_e"}, rd1_e, e.rd1);
                    chk({e.tag, ".rd2_e"}, rd2_e, e.rd2);
                    chk({e.tag, ".simm_e"}, simm_e, e.simm);
                    chk({e.tag, ".pcp4_e"}, pcp4_e, e.pcp4);
                    chk({e.tag, ".regs_e"}, 32'({rs_e, rt_e, rd_e, shamt_e}), 32'(e.regs));
                end
            end
        end
    end

    initial begin : stimulus
        int bc;
        reset = 1; valid_d = 0; ctl_d = '0; rd1_d = '0; rd2_d = '0; simm_d = '0; pcp4_d = '0;
        rs_d = '0; rt_d = '0; rd_d = '0; shamt_d = '0; stall_e = 0; flush_e = 0;
        #3;
        chk("rst.valid_e", 32'(valid_e), 32'd0);
        chk("rst.ctl_e", 32'(ctl_e), 32'd0);
        chk("rst.bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("rst.rd1_e", rd1_e, 32'd0);
        chk("rst.stall_fd", 32'(stall_fd), 32'd0);
        stall_e = 1;
        #1;
        chk("rst.stall_fd_pass", 32'(stall_fd), 32'd1);
        stall_e = 0;
        @(negedge clk);
        reset = 0;

        // rt_e == 0 never hazards
        step("lw_r0",    1, C_LW,  5'd1, 5'd0,  0, 0, 0, 1, C_LW,  4'd0, LOAD);
        step("add_r0",   1, C_ADD, 5'd0, 5'd0,  0, 0, 0, 1, C_ADD, 4'd0, LOAD);
        // classic load-use: one bubble then the consumer loads
        step("lw_t0",    1, C_LW,  5'd9, 5'd8,  0, 0, 0, 1, C_LW,  4'd0, LOAD);
        step("lu_bub",   1, C_ADD, 5'd8, 5'd10, 0, 0, 1, 0, 12'h0, 4'd1, BUB);
        step("lu_after", 1, C_ADD, 5'd8, 5'd10, 0, 0, 0, 1, C_ADD, 4'd1, LOAD);
        // flush beats load-use (match on rt)
        step("lw_t0b",   1, C_LW,  5'd2, 5'd8,  0, 0, 0, 1, C_LW,  4'd1, LOAD);
        step("fl_lu",    1, C_SUB, 5'd3, 5'd8,  0, 1, 0, 0, 12'h0, 4'd1, BUB);
        // stall holds for 3 cycles, bubble on release
        step("lw_t1",    1, C_LW,  5'd2, 5'd9,  0, 0, 0, 1, C_LW,  4'd1, LOAD);
        step("st_h1",    1, C_ADD, 5'd9, 5'd4,  1, 0, 1, 1, C_LW,  4'd1, HOLD);
        step("st_h2",    1, C_ADD, 5'd9, 5'd4,  1, 0, 1, 1, C_LW,  4'd1, HOLD);
        step("st_h3",    1, C_ADD, 5'd9, 5'd4,  1, 0, 1, 1, C_LW,  4'd1, HOLD);
        step("st_rel",   1, C_ADD, 5'd9, 5'd4,  0, 0, 1, 0, 12'h0, 4'd2, BUB);
        step("st_load",  1, C_ADD, 5'd9, 5'd4,  0, 0, 0, 1, C_ADD, 4'd2, LOAD);
        // invalid instruction with undefined control
        step("inv_x",    0, 12'hxxx, 5'd1, 5'd2, 0, 0, 0, 0, 12'h0, 4'd2, LOAD);
        // stall beats flush; flush applies once stall drops
        step("lw_t2",    1, C_LW,  5'd1, 5'd7,  0, 0, 0, 1, C_LW,  4'd2, LOAD);
        step("st_fl",    1, C_ADD, 5'd5, 5'd7,  1, 1, 1, 1, C_LW,  4'd2, HOLD);
        step("fl_only",  1, C_ADD, 5'd5, 5'd7,  0, 1, 0, 0, 12'h0, 4'd2, BUB);

        // 2^CW+2 bubbles: counter must stop at all-ones
        bc = 2;
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            step("sat_lw",  1, C_LW,  5'd1, 5'd5, 0, 0, 0, 1, C_LW,  4'(bc), LOAD);
            bc = (bc < 15) ? bc + 1 : 15;
            step("sat_bub", 1, C_ADD, 5'd5, 5'd2, 0, 0, 1, 0, 12'h0, 4'(bc), BUB);
        end

        // async reset in the middle of a stalled load-use
        step("pre_rst",  1, C_LW,  5'd1, 5'd6,  0, 0, 0, 1, C_LW,  4'd15, LOAD);
        @(negedge clk);
        valid_d = 1; ctl_d = C_ADD; rs_d = 5'd6; rt_d = 5'd1; stall_e = 1; flush_e = 0;
        #1;
        chk("mid.stall_fd", 32'(stall_fd), 32'd1);
        #1;
        reset = 1;
        #1;
        chk("mid_rst.valid_e", 32'(valid_e), 32'd0);
        chk("mid_rst.ctl_e", 32'(ctl_e), 32'd0);
        chk("mid_rst.rt_e", 32'(rt_e), 32'd0);
        chk("mid_rst.pcp4_e", pcp4_e, 32'd0);
        chk("mid_rst.bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("mid_rst.stall_fd_st", 32'(stall_fd), 32'd1);
        stall_e = 0;
        #1;
        chk("mid_rst.stall_fd", 32'(stall_fd), 32'd0);
        reset = 0;
        @(posedge clk);
        #1;
        chk("post_rst.valid_e", 32'(valid_e), 32'd1);
        chk("post_rst.ctl_e", 32'(ctl_e), 32'(C_ADD));
        chk("post_rst.rs_e", 32'(rs_e), 32'd6);
        chk("post_rst.bubble_cnt", 32'(bubble_cnt), 32'd0);
        step("post_sub", 1, C_SUB, 5'd6, 5'd1,  0, 0, 0, 1, C_SUB, 4'd0, LOAD);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DW, 32, datapath word width.
REQ-002 Parameter: CW, 16, bubble-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 ctl_d  in  12  ID control bundle {RegWrite,RegDst,ALUSrc,Branch,MemWrite,MemtoReg,Jump,Bne,ALUControl[3:0]} from the decode control unit.
REQ-006 valid_d  in  1  ID holds a real instruction.
REQ-007 rd1_d, rd2_d, simm_d, pcp4_d  in  DW each  register-file reads, sign-extended immediate, PC+4.
REQ-008 rs_d, rt_d, rd_d, shamt_d  in  5 each  register specifiers and shift amount.
REQ-009 stall_e  in  1  downstream hold request; freeze EX and everything upstream.
REQ-010 flush_e  in  1  taken branch/jump resolved; kill EX contents.
REQ-011 ctl_e  out  12  registered control bundle; field order identical to ctl_d.
REQ-012 valid_e, rd1_e, rd2_e, simm_e, pcp4_e, rs_e, rt_e, rd_e, shamt_e  out  registered copies of ID inputs.
REQ-013 stall_fd  out  1  combinational freeze for PC and IF/ID register.
REQ-014 bubble_cnt  out  CW  saturating count of inserted load-use bubbles.

Function
REQ-015 Latency: one cycle; ID values appear on *_e outputs after the next rising edge when loaded.
REQ-016 Load-use hazard (lu) SHALL be: valid_e & ctl_e.MemtoReg & valid_d & rt_e!=0 & (rt_e==rs_d | rt_e==rt_d).
REQ-017 Per-edge priority SHALL be: stall_e (hold all EX registers) > flush_e (bubble) > lu (bubble) > load.
REQ-018 Bubble SHALL set valid_e=0 and ctl_e=0 (no RegWrite, MemWrite, Branch, Jump, Bne); datapath fields may retain or load values, but verification checks only valid_e and ctl_e.
REQ-019 Load SHALL copy all ID inputs; if valid_d=0, ctl_e SHALL be forced to 0.
REQ-020 stall_fd SHALL equal stall_e | (lu & ~flush_e).
REQ-021 Simultaneous flush_e and lu: flush wins, no stall_fd from lu, bubble_cnt unchanged.
REQ-022 Simultaneous stall_e with flush_e or lu: hold wins; flush_e/lu re-evaluated next cycle.
REQ-023 bubble_cnt SHALL increment by 1 on each edge where a lu bubble is inserted (lu & ~flush_e & ~stall_e); saturates at all-ones, never wraps.
REQ-024 Any ctl_d bits X/undefined with valid_d=0 SHALL not propagate: ctl_e forced 0.
REQ-025 A load-use stall SHALL last exactly one cycle: after the bubble, ctl_e.MemtoReg=0 so lu deasserts.

Reset
REQ-026 On reset assertion all outputs SHALL go to 0 asynchronously: valid_e=0, ctl_e=0, all data fields 0, bubble_cnt=0.
REQ-027 stall_fd SHALL be 0 during reset unless stall_e=1.
REQ-028 Reset mid-stall or mid-flush SHALL abandon the operation; first post-reset edge performs a normal load.

Structure
REQ-029 Shared package mips_pkg SHALL hold: control-bundle bit positions, ALUControl encodings (ADD 0000 ... LUI 1110), opcode/funct constants, bundle width 12.
REQ-030 Sub-module load_use_detect (combinational, computes lu) SHALL be instantiated once; the pipeline register and counter stay in id_ex_stage.

Verification
REQ-031 LW $t0 in EX (rt_e=8, MemtoReg=1), ADD with rs_d=8 in ID -> stall_fd=1 one cycle, next ctl_e=0/valid_e=0, bubble_cnt 0->1, ADD loaded following cycle.
REQ-032 LW with rt_e=0, consumer rs_d=0 -> no stall, no bubble, bubble_cnt stays 0.
REQ-033 flush_e=1 with lu true -> ctl_e=0, stall_fd=0, bubble_cnt unchanged.
REQ-034 stall_e=1 for 3 cycles with lu true -> EX outputs unchanged 3 cycles, stall_fd=1, bubble_cnt unchanged; bubble on first edge after release.
REQ-035 Force 2^CW+2 lu bubbles -> bubble_cnt saturates at all-ones.
REQ-036 Assert reset between edges during stall -> outputs 0 immediately, no clock needed; normal load after release.
